// File: rtl/raggedstone_spinn_aer_if_pkt_arb.sv
// raggedstone_spinn_aer_if_pkt_arb: weighted 2:1 packet arbiter feeding the SpiNNaker link sender
// Define PKT_ARB_CNT_EN to build the per-port forwarded-packet counters.
module raggedstone_spinn_aer_if_pkt_arb #(
  parameter int WEIGHT0 = 4,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                en0,
  input  logic                en1,
  input  logic [71:0]         pkt0_data,
  input  logic                pkt0_vld,
  output logic                pkt0_rdy,
  input  logic [71:0]         pkt1_data,
  input  logic                pkt1_vld,
  output logic                pkt1_rdy,
  output logic [71:0]         opkt_data,
  output logic                opkt_vld,
  input  logic                opkt_rdy,
  output logic                grant_src,
  output logic [CNT_BITS-1:0] cnt0,
  output logic [CNT_BITS-1:0] cnt1
);
  localparam logic [3:0] W = 4'(WEIGHT0);
  logic req0, req1, any_req, sel, load;
  logic [3:0] burst_cnt;
  always_comb begin
    req0 = pkt0_vld && en0;
    req1 = pkt1_vld && en1;
    any_req = req0 || req1;
    sel = !req0 || (req1 && burst_cnt == W);
    load = !opkt_vld || opkt_rdy;
    pkt0_rdy = nreset && load && req0 && !sel;
    pkt1_rdy = nreset && load && req1 && sel;
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      opkt_vld <= 1'b0;
      opkt_data <= '0;
      grant_src <= 1'b0;
      burst_cnt <= '0;
    end else begin
      if (load) begin
        opkt_vld <= any_req;
        if (any_req) begin
          opkt_data <= sel ? pkt1_data : pkt0_data;
          grant_src <= sel;
        end
      end
      if (pkt1_rdy) burst_cnt <= '0;
      else if (pkt0_rdy) burst_cnt <= !req1 ? 4'd0 : burst_cnt == W ? burst_cnt : burst_cnt + 4'd1;
    end
  end
`ifdef PKT_ARB_CNT_EN
  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      cnt0 <= cnt0 + CNT_BITS'(pkt0_rdy);
      cnt1 <= cnt1 + CNT_BITS'(pkt1_rdy);
    end
  end
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif
endmodule
